instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 84 ++++++++
 rtl/instr_sequencer_prog_buffer.sv | 39 +++
 rtl/instr_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_instr_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instr_sequencer_pkg
// Shared definitions for the instruction sequencer:
//   - opcode constants of the small register-file / ALU datapath
//   - bit positions of the fields inside a 16-bit instruction word
//   - program buffer geometry
//   - sequencer state encoding
//   - helper functions for pulling fields out of an instruction word
// -----------------------------------------------------------------------------
package instr_sequencer_pkg;

  // Opcodes. Anything above OP_LAST_LEGAL is treated as illegal: it is
  // sequenced like any other instruction but never writes the register file.
  localparam logic [3:0] OP_ADD        = 4'd0;
  localparam logic [3:0] OP_SUB        = 4'd1;
  localparam logic [3:0] OP_SLT        = 4'd2;
  localparam logic [3:0] OP_AND        = 4'd3;
  localparam logic [3:0] OP_OR         = 4'd4;
  localparam logic [3:0] OP_XOR        = 4'd5;
  localparam logic [3:0] OP_ANDI       = 4'd6;
  localparam logic [3:0] OP_ORI        = 4'd7;
  localparam logic [3:0] OP_XORI       = 4'd8;
  localparam logic [3:0] OP_ADDI       = 4'd9;
  localparam logic [3:0] OP_SUBI       = 4'd10;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

  // Instruction word layout:
  //   [15:12] opcode
  //   [11:8]  register-file write address
  //   [7:4]   read address 1 or immediate
  //   [3:0]   read address 2
  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int WA_MSB  = 11;
  localparam int WA_LSB  = 8;
  localparam int RA1_MSB = 7;
  localparam int RA1_LSB = 4;
  localparam int RA2_MSB = 3;
  localparam int RA2_LSB = 0;

  // Program buffer geometry: 16 entries, 4-bit index.
  localparam int PROG_DEPTH = 16;
  localparam int PROG_AW    = 4;

  // Sequencer states. READ, EXEC and WRITE each last exactly one cycle per
  // instruction; DONE lasts exactly one cycle per run.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // Decoded view of an instruction word.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] waddr;
    logic [3:0] raddr1;
    logic [3:0] raddr2;
  } instr_fields_t;

  // Extract the opcode field of an instruction word.
  function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  // True when the opcode is one the datapath can execute.
  function automatic logic opcode_is_legal(input logic [3:0] opcode);
    return (opcode <= OP_LAST_LEGAL);
  endfunction

  // Split an instruction word into its fields.
  function automatic instr_fields_t instr_decode(input logic [INSTR_W-1:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPC_MSB:OPC_LSB];
    f.waddr  = instr[WA_MSB:WA_LSB];
    f.raddr1 = instr[RA1_MSB:RA1_LSB];
    f.raddr2 = instr[RA2_MSB:RA2_LSB];
    return f;
  endfunction

endpackage : instr_sequencer_pkg

// File: rtl/instr_sequencer_prog_buffer.sv
// -----------------------------------------------------------------------------
// prog_buffer
// 16 x 16 program buffer for the instruction sequencer.
// One synchronous write port, one combinational (asynchronous) read port.
// The contents are deliberately not reset so that a program survives a
// sequencer reset and can be re-run.
//
// Ports:
//   i_clk      clock, writes on posedge
//   i_wr_en    write enable (already qualified by the sequencer state)
//   i_wr_addr  write address
//   i_wr_data  instruction word to store
//   i_rd_addr  read address
//   o_rd_data  instruction word at i_rd_addr, combinational
// -----------------------------------------------------------------------------
module prog_buffer
  import instr_sequencer_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [PROG_AW-1:0] i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data,
  input  logic [PROG_AW-1:0] i_rd_addr,
  output logic [INSTR_W-1:0] o_rd_data
);

  logic [INSTR_W-1:0] r_mem [0:PROG_DEPTH-1];

  // Synchronous write port; no reset on the storage array.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Combinational read port.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule : prog_buffer

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Steps through a program held in a 16-entry buffer and presents one
// instruction at a time to a register-file / ALU datapath. Each instruction
// occupies three cycles:
//   READ  - register file captures its read operands at the closing edge
//   EXEC  - ALU settles
//   WRITE - register-file write enable pulses (legal opcodes only)
// After the WRITE of the last instruction the sequencer spends one cycle in
// DONE (done pulse) and then returns to IDLE.
//
// Ports:
//   i_clk           clock, all state updates on posedge
//   i_reset         synchronous active-high reset
//   i_load_en       write i_load_data into buffer entry i_load_addr (IDLE only)
//   i_load_addr     program buffer write address
//   i_load_data     instruction word to load
//   i_start         begin a run at entry 0 (IDLE only)
//   i_prog_last     index of the last instruction, sampled with i_start
//   o_instruction   instruction word presented to the datapath
//   o_enable_write  register-file write enable
//   o_pc            index of the instruction on o_instruction
//   o_busy          high in READ, EXEC and WRITE
//   o_done          one-cycle pulse at the end of a run
//   o_illegal       sticky: the current/last run contained an opcode above 10
// All outputs are driven directly from registers.
// -----------------------------------------------------------------------------
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_en,
  input  logic [PROG_AW-1:0] i_load_addr,
  input  logic [INSTR_W-1:0] i_load_data,
  input  logic               i_start,
  input  logic [PROG_AW-1:0] i_prog_last,
  output logic [INSTR_W-1:0] o_instruction,
  output logic               o_enable_write,
  output logic [PROG_AW-1:0] o_pc,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_illegal
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  seq_state_e         r_state;
  logic [PROG_AW-1:0] r_pc;
  logic [PROG_AW-1:0] r_last;
  logic [INSTR_W-1:0] r_instruction;
  logic               r_enable_write;
  logic               r_busy;
  logic               r_done;
  logic               r_illegal;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic               w_idle;
  logic               w_buf_wr_en;
  logic [PROG_AW-1:0] w_rd_addr;
  logic [INSTR_W-1:0] w_rd_data;
  logic [INSTR_W-1:0] w_first_instr;
  logic               w_cur_legal;
  logic               w_at_last;

  assign w_idle      = (r_state == ST_IDLE);
  // Loads are only accepted while idle so a running program cannot be
  // modified underneath the sequencer.
  assign w_buf_wr_en = i_load_en & w_idle;
  assign w_cur_legal = opcode_is_legal(instr_opcode(r_instruction));
  assign w_at_last   = (r_pc == r_last);

  // Read address: entry 0 while waiting for a start, otherwise the entry
  // following the current one (fetched at the WRITE -> READ edge).
  always_comb begin
    w_rd_addr = {PROG_AW{1'b0}};
    if (w_idle) begin
      w_rd_addr = {PROG_AW{1'b0}};
    end else begin
      w_rd_addr = r_pc + 4'd1;
    end
  end

  // First instruction of a run. A load to entry 0 in the same cycle as the
  // start is forwarded so the run begins with the freshly loaded word.
  always_comb begin
    w_first_instr = w_rd_data;
    if (i_load_en && (i_load_addr == 4'd0)) begin
      w_first_instr = i_load_data;
    end else begin
      w_first_instr = w_rd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Program buffer
  // ---------------------------------------------------------------------------
  prog_buffer u_prog_buffer (
    .i_clk     (i_clk),
    .i_wr_en   (w_buf_wr_en),
    .i_wr_addr (i_load_addr),
    .i_wr_data (i_load_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  // State, program counter and all outputs advance together on the clock edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_pc           <= 4'd0;
      r_last         <= 4'd0;
      r_instruction  <= 16'h0000;
      r_enable_write <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // pc and instruction keep their previous values until a start.
          r_enable_write <= 1'b0;
          r_done         <= 1'b0;
          if (i_start) begin
            r_pc          <= 4'd0;
            r_instruction <= w_first_instr;
            r_last        <= i_prog_last;
            r_illegal     <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= ST_READ;
          end
        end

        ST_READ: begin
          r_state <= ST_EXEC;
        end

        ST_EXEC: begin
          // Raise the write enable for exactly the WRITE cycle of legal ops.
          r_enable_write <= w_cur_legal;
          r_state        <= ST_WRITE;
        end

        ST_WRITE: begin
          r_enable_write <= 1'b0;
          if (!w_cur_legal) begin
            r_illegal <= 1'b1;
          end
          if (!w_at_last) begin
            r_pc          <= r_pc + 4'd1;
            r_instruction <= w_rd_data;
            r_state       <= ST_READ;
          end else begin
            // Stop on the last entry; pc is never advanced past it, so
            // prog_last = 15 cannot wrap back to entry 0.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          // Unreachable encodings recover to a quiet IDLE.
          r_enable_write <= 1'b0;
          r_busy         <= 1'b0;
          r_done         <= 1'b0;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_instruction  = r_instruction;
  assign o_enable_write = r_enable_write;
  assign o_pc           = r_pc;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_illegal      = r_illegal;

endmodule : instr_sequencer

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Self-checking bench for instr_sequencer. A behavioural model (an array of
// program words plus per-cycle arithmetic on the run position) predicts every
// output in every cycle of each run.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic [3:0]  prog_last;
  logic [15:0] instruction;
  logic        enable_write;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  logic        illegal;

  int tests = 0;
  int fails = 0;

  // Reference program buffer.
  logic [15:0] mem [16];

  always #5 clk = ~clk;

  instr_sequencer dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_load_en      (load_en),
    .i_load_addr    (load_addr),
    .i_load_data    (load_data),
    .i_start        (start),
    .i_prog_last    (prog_last),
    .o_instruction  (instruction),
    .o_enable_write (enable_write),
    .o_pc           (pc),
    .o_busy         (busy),
    .o_done         (done),
    .o_illegal      (illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] e_instr, input logic [3:0] e_pc,
                          input logic e_ew, input logic e_busy, input logic e_done,
                          input logic e_ill);
    chk({tag, ".instruction"}, {16'h0, instruction}, {16'h0, e_instr});
    chk({tag, ".pc"}, {28'h0, pc}, {28'h0, e_pc});
    chk({tag, ".enable_write"}, {31'h0, enable_write}, {31'h0, e_ew});
    chk({tag, ".busy"}, {31'h0, busy}, {31'h0, e_busy});
    chk({tag, ".done"}, {31'h0, done}, {31'h0, e_done});
    chk({tag, ".illegal"}, {31'h0, illegal}, {31'h0, e_ill});
  endtask

  task automatic load(input logic [3:0] addr, input logic [15:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en   = 1'b0;
    mem[addr] = data;
  endtask

  // Random instruction word; roughly one in four has an illegal opcode.
  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(3, 0) != 0) w[15:12] = 4'($urandom_range(10, 0));
    else w[15:12] = 4'($urandom_range(15, 11));
    return w;
  endfunction

  // Full run from the start edge to the first IDLE cycle, checked every cycle.
  // Cycle c (1-based after the start edge) of a run of n instructions:
  //   c <= 3n : instruction index (c-1)/3, phase (c-1)%3, write on phase 2
  //   c = 3n+1: done pulse
  task automatic run(input string name, input logic [3:0] last, input bit disturb,
                     input bit wt, input logic [15:0] wt_data);
    logic [15:0] prog [16];
    int          n;
    int          i;
    int          ph;
    bit          e_ill;
    bit          any_ill;
    if (wt) begin
      load_en   = 1'b1;
      load_addr = 4'd0;
      load_data = wt_data;
      mem[0]    = wt_data;
    end
    start     = 1'b1;
    prog_last = last;
    tick();
    start     = 1'b0;
    load_en   = 1'b0;
    prog_last = 4'($urandom);
    prog      = mem;
    n         = int'(last) + 1;
    any_ill   = 1'b0;
    for (int j = 0; j < n; j++) if (prog[j][15:12] > 4'd10) any_ill = 1'b1;
    for (int c = 1; c <= 3 * n + 1; c++) begin
      if (c <= 3 * n) begin
        i     = (c - 1) / 3;
        ph    = (c - 1) % 3;
        e_ill = 1'b0;
        for (int j = 0; j < n; j++)
          if (prog[j][15:12] > 4'd10 && 3 * j + 3 <= c - 1) e_ill = 1'b1;
        chk_outs($sformatf("%s.c%0d", name, c), prog[i], 4'(i),
                 (ph == 2) && (prog[i][15:12] <= 4'd10), 1'b1, 1'b0, e_ill);
      end else begin
        chk_outs($sformatf("%s.done_c%0d", name, c), prog[n-1], last, 1'b0, 1'b0, 1'b1, any_ill);
      end
      if (disturb) begin
        start     = 1'($urandom);
        load_en   = 1'b1;
        load_addr = 4'($urandom);
        load_data = 16'($urandom);
        prog_last = 4'($urandom);
      end
      tick();
    end
    start   = 1'b0;
    load_en = 1'b0;
    chk_outs({name, ".idle"}, prog[n-1], last, 1'b0, 1'b0, 1'b0, any_ill);
  endtask

  initial begin
    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = 4'd0;
    load_data = 16'h0000;
    start     = 1'b0;
    prog_last = 4'd0;
    tick();
    tick();
    chk_outs("reset", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_outs("reset_idle", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill the whole buffer so the model knows every entry.
    for (int a = 0; a < 16; a++) load(4'(a), rand_instr());

    // Single instruction.
    load(4'd0, 16'h0373);
    run("single", 4'd0, 1'b0, 1'b0, 16'h0);

    // Three legal instructions with opcodes 0, 9, 1.
    load(4'd0, {4'd0, 12'($urandom)});
    load(4'd1, {4'd9, 12'($urandom)});
    load(4'd2, {4'd1, 12'($urandom)});
    run("three", 4'd2, 1'b0, 1'b0, 16'h0);

    // Illegal opcode in entry 1, then the next start clears the flag.
    load(4'd0, 16'h2345);
    load(4'd1, 16'hB123);
    run("illegal", 4'd1, 1'b0, 1'b0, 16'h0);
    run("ill_clear", 4'd0, 1'b0, 1'b0, 16'h0);

    // Reset during EXEC of entry 2, then restart with the buffer intact.
    for (int a = 0; a < 4; a++) load(4'(a), {4'($urandom_range(10, 0)), 12'($urandom)});
    start     = 1'b1;
    prog_last = 4'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk_outs("pre_reset_exec2", mem[2], 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_outs("midrun_reset", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_outs("midrun_reset_idle", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("restart", 4'd3, 1'b0, 1'b0, 16'h0);

    // start/load_en while busy are ignored; then write-through at entry 0.
    run("disturb", 4'd2, 1'b1, 1'b0, 16'h0);
    run("readback", 4'd15, 1'b0, 1'b0, 16'h0);
    run("writethru", 4'd2, 1'b0, 1'b1, 16'h4512);

    // All 16 entries zero, prog_last = 15.
    for (int a = 0; a < 16; a++) load(4'(a), 16'h0000);
    run("full16", 4'd15, 1'b0, 1'b0, 16'h0);

    // Randomised programs and lengths.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 6; k++) load(4'($urandom), rand_instr());
      run($sformatf("rand%0d", r), 4'($urandom_range(15, 0)), r[0], r[1], rand_instr());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_instr_sequencer
